// File: rtl/otter_intc_pkg.sv
// otter_intc_pkg: shared FSM state type and register-map offsets for the Otter interrupt controller
package otter_intc_pkg;
   typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} intc_state_t;
   localparam logic [3:0] OFF_PENDING = 4'h0;
   localparam logic [3:0] OFF_ENABLE  = 4'h4;
   localparam logic [3:0] OFF_CLAIM   = 4'h8;
   localparam logic [3:0] OFF_STATUS  = 4'hC;
   localparam int         ST_ERR_BIT  = 2;
endpackage

// File: rtl/otter_intr_ctrl_if.sv
// otter_intr_ctrl_if: CPU IOBUS view of the interrupt controller
//   addr/wdata/wr : CPU address, write data, write strobe
//   rd_data/hit   : combinational read data and window-hit flag back to the CPU
interface otter_intr_ctrl_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        wr;
   logic [31:0] rd_data;
   logic        hit;
   modport master (output addr, wdata, wr, input rd_data, hit);
   modport slave (input addr, wdata, wr, output rd_data, hit);
endinterface

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: fixed-priority encoder, lowest set index wins
//   req   : request vector
//   valid : any request set
//   id    : index of the lowest set request (0 when none)
module intc_prio_enc #(
   parameter int N = 8
) (
   input  logic [N-1:0] req,
   output logic         valid,
   output logic [4:0]   id
);
   assign valid = |req;
   always_comb begin
      id = '0;
      for (int i = N - 1; i >= 0; i--) if (req[i]) id = 5'(i);
   end
endmodule

// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: memory-mapped interrupt controller driving the Otter INTR pin
//   clk, rst : clock, asynchronous active-high reset
//   irq_src  : rising-edge sensitive interrupt sources, index 0 highest priority
//   intr     : interrupt request to the CPU, high only in the ASSERT state
//   bus      : IOBUS slave (PENDING, ENABLE, CLAIM, STATUS at BASE_ADDR+0x0..0xC)
module otter_intr_ctrl
   import otter_intc_pkg::*;
#(
   parameter int          NUM_SRC   = 8,
   parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_src,
   output logic               intr,
   otter_intr_ctrl_if.slave   bus
);
   intc_state_t        state, state_next;
   logic [NUM_SRC-1:0] pending, enable, irq_prev, rise, w1c, claim_clr;
   logic [7:0]         in_service_id;
   logic               err, valid;
   logic [4:0]         id;
   logic [3:0]         off;
   logic               wr_pend, wr_en, wr_claim, wr_stat, claim_do, eoi_ok, eoi_bad;
   logic               unused_bits;
   intc_prio_enc #(.N(NUM_SRC)) u_enc (.req(pending & enable), .valid(valid), .id(id));
   assign unused_bits = ^{bus.wdata, bus.addr[1:0]};
   assign off       = {bus.addr[3:2], 2'b00};
   assign bus.hit   = bus.addr[31:4] == BASE_ADDR[31:4];
   assign wr_pend   = bus.wr && bus.hit && off == OFF_PENDING;
   assign wr_en     = bus.wr && bus.hit && off == OFF_ENABLE;
   assign wr_claim  = bus.wr && bus.hit && off == OFF_CLAIM;
   assign wr_stat   = bus.wr && bus.hit && off == OFF_STATUS;
   assign rise      = irq_src & ~irq_prev;
   assign w1c       = wr_pend ? bus.wdata[NUM_SRC-1:0] : '0;
   // claim captures the winner seen in the write cycle, before any W1C lands
   assign claim_do  = wr_claim && state == ASSERT && valid;
   assign claim_clr = claim_do ? NUM_SRC'(1) << id : '0;
   assign eoi_ok    = wr_stat && state == SERVICE && bus.wdata[15:8] == in_service_id;
   assign eoi_bad   = wr_stat && state == SERVICE && bus.wdata[15:8] != in_service_id;
   assign intr      = state == ASSERT;
   assign bus.rd_data = !bus.hit ? 32'h0 :
                        off == OFF_PENDING ? 32'(pending) :
                        off == OFF_ENABLE  ? 32'(enable) :
                        off == OFF_CLAIM   ? {valid, 26'b0, id} :
                        {16'b0, in_service_id, 5'b0, err, state == SERVICE, state == ASSERT};
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = valid ? ASSERT : IDLE;
         ASSERT:  state_next = claim_do ? SERVICE : valid ? ASSERT : IDLE;
         SERVICE: state_next = eoi_ok ? IDLE : SERVICE;
         default: state_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         pending       <= '0;
         enable        <= '0;
         irq_prev      <= '1;
         in_service_id <= '0;
         err           <= 1'b0;
      end else begin
         state    <= state_next;
         irq_prev <= irq_src;
         // OR-ing the edge in last makes a same-cycle set beat any clear
         pending  <= (pending & ~w1c & ~claim_clr) | rise;
         if (wr_en) enable <= bus.wdata[NUM_SRC-1:0];
         if (claim_do) in_service_id <= 8'(id);
         err      <= (err & ~(wr_stat & bus.wdata[ST_ERR_BIT])) | eoi_bad;
      end
   end
endmodule

// File: tb/tb_otter_intr_ctrl.sv
// tb_otter_intr_ctrl: directed and randomized checks of otter_intr_ctrl against a behavioural model
module tb_otter_intr_ctrl;
   import otter_intc_pkg::*;
   localparam logic [31:0] BASE = 32'h1100_0100;
   localparam int M_IDLE = 0, M_ASSERT = 1, M_SERVICE = 2;
   logic       clk = 0, rst = 1, intr;
   logic [7:0] irq = 0;
   otter_intr_ctrl_if bus ();
   otter_intr_ctrl #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .irq_src(irq), .intr(intr), .bus(bus));
   always #10 clk = ~clk;
   int passed = 0, total = 0;
   logic [7:0] m_pend, m_en, m_prev, m_isid;
   logic       m_err;
   int         m_st;
   logic [31:0] d;
   function automatic int m_win();
      for (int i = 0; i < 8; i++) if (m_pend[i] && m_en[i]) return i;
      return 0;
   endfunction
   function automatic logic [31:0] m_read(input int o);
      if (o == 0) return {24'b0, m_pend};
      if (o == 1) return {24'b0, m_en};
      if (o == 2) return {((m_pend & m_en) != 0), 26'b0, 5'(m_win())};
      return {16'b0, m_isid, 5'b0, m_err, m_st == M_SERVICE, m_st == M_ASSERT};
   endfunction
   task automatic model_reset();
      m_pend = 0; m_en = 0; m_prev = 8'hFF; m_isid = 0; m_err = 0; m_st = M_IDLE;
   endtask
   task automatic tick();
      logic [7:0] clr, n_en, n_isid;
      logic n_err, v, h;
      int n_st, o, w;
      v = (m_pend & m_en) != 0; w = m_win();
      h = bus.wr && bus.addr[31:4] == BASE[31:4];
      o = int'(bus.addr[3:2]);
      clr = 0; n_en = m_en; n_isid = m_isid; n_st = m_st; n_err = m_err;
      if (h && o == 0) clr = bus.wdata[7:0];
      if (h && o == 1) n_en = bus.wdata[7:0];
      if (h && o == 3 && bus.wdata[2]) n_err = 0;
      if (m_st == M_IDLE && v) n_st = M_ASSERT;
      if (m_st == M_ASSERT) begin
         if (h && o == 2 && v) begin n_st = M_SERVICE; clr = clr | 8'(1 << w); n_isid = 8'(w); end
         else if (!v) n_st = M_IDLE;
      end
      if (m_st == M_SERVICE && h && o == 3) begin
         if (bus.wdata[15:8] == m_isid) n_st = M_IDLE; else n_err = 1;
      end
      @(posedge clk); #1;
      m_pend = (m_pend & ~clr) | (irq & ~m_prev);
      m_prev = irq; m_en = n_en; m_isid = n_isid; m_st = n_st; m_err = n_err;
   endtask
   task automatic do_reset();
      bus.wr = 0; rst = 1; model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 0;
   endtask
   task automatic bus_wr(input logic [3:0] off, input logic [31:0] dat);
      bus.addr = BASE + 32'(off); bus.wdata = dat; bus.wr = 1;
      tick();
      bus.wr = 0;
   endtask
   task automatic bus_rd(input logic [3:0] off, output logic [31:0] dat);
      bus.addr = BASE + 32'(off); #1 dat = bus.rd_data;
   endtask
   task automatic test_reset();
      do_reset();
      total++; if (intr !== 1'b0) $display("FAIL reset_intr got %b want 0", intr); else passed++;
      bus_rd(OFF_PENDING, d);
      total++; if (d !== 32'h0) $display("FAIL reset_pending got %h want 0", d); else passed++;
      bus_rd(OFF_STATUS, d);
      total++; if (d !== 32'h0) $display("FAIL reset_status got %h want 0", d); else passed++;
      bus.addr = BASE + 32'h10; #1;
      total++; if (bus.hit !== 1'b0 || bus.rd_data !== 32'h0) $display("FAIL out_of_window hit %b data %h want 0/0", bus.hit, bus.rd_data); else passed++;
   endtask
   task automatic test_single_src();
      do_reset();
      bus_wr(OFF_ENABLE, 32'h1);
      irq = 8'h01; tick(); irq = 0;
      total++; if (intr !== 1'b0) $display("FAIL t1_intr_k got %b want 0", intr); else passed++;
      tick();
      total++; if (intr !== 1'b1) $display("FAIL t1_intr_k1 got %b want 1", intr); else passed++;
      bus_rd(4'h9, d);
      total++; if (d !== 32'h8000_0000) $display("FAIL t1_claim got %h want 80000000", d); else passed++;
   endtask
   task automatic test_two_src();
      do_reset();
      bus_wr(OFF_ENABLE, 32'hFF);
      irq = 8'h24; tick(); irq = 0; tick();
      bus_rd(OFF_CLAIM, d);
      total++; if (d !== 32'h8000_0002) $display("FAIL t2_claim2 got %h want 80000002", d); else passed++;
      bus_wr(OFF_CLAIM, 32'h0);
      total++; if (intr !== 1'b0) $display("FAIL t2_intr_claim got %b want 0", intr); else passed++;
      bus_rd(OFF_PENDING, d);
      total++; if (d !== 32'h20) $display("FAIL t2_pending got %h want 20", d); else passed++;
      bus_rd(OFF_STATUS, d);
      total++; if (d !== 32'h0202) $display("FAIL t2_status got %h want 0202", d); else passed++;
      bus_wr(OFF_STATUS, 32'h0200);
      total++; if (intr !== 1'b0) $display("FAIL t2_intr_eoi got %b want 0", intr); else passed++;
      tick();
      total++; if (intr !== 1'b1) $display("FAIL t2_intr_reassert got %b want 1", intr); else passed++;
      bus_rd(OFF_CLAIM, d);
      total++; if (d !== 32'h8000_0005) $display("FAIL t2_claim5 got %h want 80000005", d); else passed++;
   endtask
   task automatic test_eoi_err();
      do_reset();
      bus_wr(OFF_ENABLE, 32'hFF);
      irq = 8'h08; tick(); irq = 0; tick();
      bus_wr(OFF_CLAIM, 32'h0);
      bus_wr(OFF_STATUS, 32'h0400);
      bus_rd(OFF_STATUS, d);
      total++; if (d !== 32'h0306) $display("FAIL t3_err got %h want 0306", d); else passed++;
      bus_wr(OFF_STATUS, 32'h0304);
      bus_rd(OFF_STATUS, d);
      total++; if (d !== 32'h0300) $display("FAIL t3_clear got %h want 0300", d); else passed++;
   endtask
   task automatic test_held_irq();
      irq = 8'h02; do_reset(); tick(); tick();
      bus_rd(OFF_PENDING, d);
      total++; if (d !== 32'h0) $display("FAIL t4_held got %h want 0", d); else passed++;
      irq = 0; tick(); irq = 8'h02; tick();
      bus_rd(OFF_PENDING, d);
      total++; if (d !== 32'h02) $display("FAIL t4_raise got %h want 02", d); else passed++;
      irq = 0;
   endtask
   task automatic test_w1c_race();
      do_reset(); tick();
      irq = 8'h10; bus_wr(OFF_PENDING, 32'h10);
      bus_rd(OFF_PENDING, d);
      total++; if (d !== 32'h10) $display("FAIL t5_set_wins got %h want 10", d); else passed++;
      bus_wr(OFF_ENABLE, 32'h10); tick();
      total++; if (intr !== 1'b1) $display("FAIL t5_assert got %b want 1", intr); else passed++;
      bus_wr(OFF_ENABLE, 32'h0); tick();
      total++; if (intr !== 1'b0) $display("FAIL t5_mask got %b want 0", intr); else passed++;
      bus_rd(OFF_STATUS, d);
      total++; if (d !== 32'h0) $display("FAIL t5_idle got %h want 0", d); else passed++;
      irq = 0;
   endtask
   task automatic test_async_reset();
      do_reset();
      bus_wr(OFF_ENABLE, 32'hFF);
      irq = 8'h40; tick(); irq = 0; tick();
      bus_wr(OFF_CLAIM, 32'h0);
      #2 rst = 1; model_reset(); #1;
      total++; if (intr !== 1'b0) $display("FAIL t6_intr got %b want 0", intr); else passed++;
      bus_rd(OFF_STATUS, d);
      total++; if (d !== 32'h0) $display("FAIL t6_status got %h want 0", d); else passed++;
      bus_rd(OFF_ENABLE, d);
      total++; if (d !== 32'h0) $display("FAIL t6_enable got %h want 0", d); else passed++;
      @(posedge clk); #1 rst = 0;
      bus_wr(OFF_CLAIM, 32'h0);
      bus_rd(OFF_STATUS, d);
      total++; if (d !== 32'h0) $display("FAIL t6_idle_claim got %h want 0", d); else passed++;
   endtask
   task automatic test_random();
      int r, o;
      do_reset();
      bus_wr(OFF_ENABLE, 32'hFF);
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
         r = $urandom_range(0, 11);
         bus.wdata = $urandom;
         bus.addr = BASE + 32'({r[1:0], 2'b00});
         bus.wr = r < 6;
         if (r == 3 && $urandom_range(0, 1) == 1) bus.wdata[15:8] = m_isid;
         if (r == 5) bus.addr = BASE + 32'h20;
         if (r == 0 || r == 1) bus.wdata = bus.wdata & 32'($urandom);
         tick();
         bus.wr = 0;
         total++; if (intr !== (m_st == M_ASSERT)) $display("FAIL rnd_intr cyc %0d got %b want %b", n, intr, m_st == M_ASSERT); else passed++;
         o = $urandom_range(0, 3);
         bus_rd(4'(o * 4), d);
         total++; if (d !== m_read(o)) $display("FAIL rnd_read cyc %0d off %0d got %h want %h", n, o, d, m_read(o)); else passed++;
      end
   endtask
   initial begin
      bus.addr = 0; bus.wdata = 0; bus.wr = 0;
      model_reset();
      test_reset();
      test_single_src();
      test_two_src();
      test_eoi_err();
      test_held_irq();
      test_w1c_race();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
